// File: rtl/mmu_seq_ctrl.sv
// Sequencer feeding the MMU core from the input register file and capturing its results.
// Optional watchdog in WAIT is enabled by defining MMU_TIMEOUT_EN.
module mmu_seq_ctrl #(
  parameter int NUM_IN_WORDS   = 64,
  parameter int NUM_OUT        = 160,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        clear_i,
  output logic [5:0]  in_addr_o,
  input  logic [31:0] in_rdata_i,
  output logic        out_we_o,
  output logic [7:0]  out_addr_o,
  output logic [8:0]  out_wdata_o,
  output logic [7:0]  mmu_input_data_o,
  output logic        mmu_valid_input_o,
  input  logic        mmu_read_ram_i,
  input  logic [8:0]  mmu_read_data_i,
  input  logic        mmu_finish_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  result_cnt_o
);

  localparam int NBYTES = 4 * NUM_IN_WORDS;
  localparam int BC_W   = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [BC_W-1:0] byte_cnt;
  logic [7:0]      out_cnt;
  logic            err;
  logic            out_full;
  logic            overflow;
  logic            wd_expired;

  assign out_full = (out_cnt == 8'(NUM_OUT));
  assign overflow = (state == S_WAIT) && mmu_read_ram_i && out_full;

`ifdef MMU_TIMEOUT_EN
  logic [15:0] wd_cnt;
  // Expiry only counts when the core has not finished in the very same cycle.
  assign wd_expired = (state == S_WAIT) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1)) && !mmu_finish_i;
`else
  assign wd_expired = 1'b0;
`endif

  assign in_addr_o         = byte_cnt[BC_W-1:2];
  assign mmu_valid_input_o = (state == S_LOAD);
  assign mmu_input_data_o  = (state == S_LOAD) ? in_rdata_i[{byte_cnt[1:0], 3'b000} +: 8] : 8'd0;
  assign out_we_o          = (state == S_WAIT) && mmu_read_ram_i && !out_full;
  assign out_addr_o        = out_cnt;
  assign out_wdata_o       = out_we_o ? mmu_read_data_i : 9'd0;
  assign busy_o            = (state == S_LOAD) || (state == S_WAIT);
  assign done_o            = (state == S_DONE);
  assign err_o             = err;
  assign result_cnt_o      = out_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      out_cnt  <= '0;
      err      <= 1'b0;
`ifdef MMU_TIMEOUT_EN
      wd_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state    <= S_LOAD;
            byte_cnt <= '0;
            out_cnt  <= '0;
            err      <= 1'b0;
          end else if (clear_i) begin
            err <= 1'b0;
          end
        end
        S_LOAD: begin
          byte_cnt <= byte_cnt + 1'b1;
          // Core activity while bytes are still streaming is a protocol error.
          if (mmu_read_ram_i || mmu_finish_i) err <= 1'b1;
          else if (clear_i)                   err <= 1'b0;
          if (byte_cnt == BC_W'(NBYTES - 1)) begin
            state <= S_WAIT;
`ifdef MMU_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (out_we_o) out_cnt <= out_cnt + 1'b1;
          if (overflow || wd_expired) err <= 1'b1;
          else if (clear_i)           err <= 1'b0;
          if (mmu_finish_i || wd_expired) state <= S_DONE;
`ifdef MMU_TIMEOUT_EN
          wd_cnt <= wd_cnt + 1'b1;
`endif
        end
        S_DONE: begin
          if (start_i) begin
            state    <= S_LOAD;
            byte_cnt <= '0;
            out_cnt  <= '0;
            err      <= 1'b0;
          end else if (clear_i) begin
            state <= S_IDLE;
            err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Bench for mmu_seq_ctrl: directed scenarios plus random traffic against a run-level model.
module tb_mmu_seq_ctrl;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, clear = 1'b0, read_ram = 1'b0, finish = 1'b0;
  logic [8:0]  read_data = 9'd0;
  logic [5:0]  in_addr;
  logic [31:0] in_rdata;
  logic        out_we, mmu_valid, busy, done, err;
  logic [7:0]  out_addr, mmu_data, result_cnt;
  logic [8:0]  out_wdata;
  logic [31:0] in_mem [64];

  assign in_rdata = in_mem[in_addr];
  always #5 clk = ~clk;

  mmu_seq_ctrl #(.NUM_IN_WORDS(64), .NUM_OUT(160), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start_i(start), .clear_i(clear),
    .in_addr_o(in_addr), .in_rdata_i(in_rdata),
    .out_we_o(out_we), .out_addr_o(out_addr), .out_wdata_o(out_wdata),
    .mmu_input_data_o(mmu_data), .mmu_valid_input_o(mmu_valid),
    .mmu_read_ram_i(read_ram), .mmu_read_data_i(read_data), .mmu_finish_i(finish),
    .busy_o(busy), .done_o(done), .err_o(err), .result_cnt_o(result_cnt)
  );

  int total = 0, bad = 0;

  // Run-level model: phase of the run, bytes delivered, results captured, sticky error.
  int m_phase = 0;   // 0 idle, 1 streaming, 2 collecting, 3 finished
  int m_bytes = 0;
  int m_res   = 0;
  int m_wait  = 0;
  bit m_err   = 0;

  int s_valid, s_data, s_addr, s_we, s_oaddr, s_wdata, s_busy, s_done, s_err, s_cnt;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sample();
    s_valid = int'(mmu_valid); s_data = int'(mmu_data); s_addr = int'(in_addr);
    s_we = int'(out_we); s_oaddr = int'(out_addr); s_wdata = int'(out_wdata);
    s_busy = int'(busy); s_done = int'(done); s_err = int'(err); s_cnt = int'(result_cnt);
  endtask

  task automatic check_all();
    int exp_we;
    chk("valid", s_valid, int'(m_phase == 1));
    if (m_phase == 1) begin
      chk("in_addr", s_addr, m_bytes / 4);
      chk("byte", s_data, int'((in_mem[m_bytes / 4] >> (8 * (m_bytes % 4))) & 32'hFF));
    end
    exp_we = int'(m_phase == 2 && read_ram && m_res < 160);
    chk("out_we", s_we, exp_we);
    if (exp_we != 0) begin
      chk("out_addr", s_oaddr, m_res);
      chk("out_wdata", s_wdata, int'(read_data));
    end
    chk("busy", s_busy, int'(m_phase == 1 || m_phase == 2));
    chk("done", s_done, int'(m_phase == 3));
    chk("err", s_err, int'(m_err));
    chk("result_cnt", s_cnt, m_res);
  endtask

  function automatic void model_begin_run();
    m_phase = 1; m_bytes = 0; m_res = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit st, bit cl, bit rr, bit fn);
    bit raise;
    case (m_phase)
      0: if (st) model_begin_run(); else if (cl) m_err = 0;
      1: begin
        if (rr || fn) m_err = 1; else if (cl) m_err = 0;
        m_bytes++;
        if (m_bytes == 256) begin m_phase = 2; m_wait = 0; end
      end
      2: begin
        raise = 0;
        if (rr) begin
          if (m_res < 160) m_res++; else raise = 1;
        end
`ifdef MMU_TIMEOUT_EN
        if (!fn && m_wait == TMO - 1) begin raise = 1; m_phase = 3; end
`endif
        if (raise) m_err = 1; else if (cl) m_err = 0;
        if (fn) m_phase = 3;
        m_wait++;
      end
      default: if (st) model_begin_run(); else if (cl) begin m_phase = 0; m_err = 0; end
    endcase
  endfunction

  task automatic cyc(input bit st, input bit cl, input bit rr, input logic [8:0] rd, input bit fn);
    @(negedge clk);
    start = st; clear = cl; read_ram = rr; read_data = rd; finish = fn;
    #1;
    sample();
    check_all();
    @(posedge clk);
    model_step(st, cl, rr, fn);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 9'd0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; clear = 0; read_ram = 0; finish = 0;
    #1;
    m_phase = 0; m_bytes = 0; m_res = 0; m_err = 0;
    sample();
    check_all();
    chk("busy_at_reset", s_busy, 0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int nw;
    int lit_bytes [8];
    lit_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 64; i++) in_mem[i] = $urandom;
    in_mem[0] = 32'h44332211;
    in_mem[1] = 32'h88776655;

    #1;
    sample();
    chk("rst_valid", s_valid, 0); chk("rst_we", s_we, 0); chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0); chk("rst_err", s_err, 0); chk("rst_cnt", s_cnt, 0);
    chk("rst_in_addr", s_addr, 0); chk("rst_data", s_data, 0);
    @(negedge clk);
    rst = 0;

    // Start at cycle 0, byte order and address sequence, start ignored at cycle 100.
    cyc(1, 0, 0, 9'd0, 0);
    for (int c = 1; c <= 8; c++) begin
      idle(1);
      chk("lit_valid", s_valid, 1);
      chk("lit_byte", s_data, lit_bytes[c - 1]);
      chk("lit_addr", s_addr, (c - 1) / 4);
    end
    for (int c = 9; c <= 256; c++) cyc(c == 100, 0, 0, 9'd0, 0);
    idle(1);
    chk("wait_busy_257", s_busy, 1);
    chk("wait_valid_257", s_valid, 0);

    // 160 results then finish.
    nw = 0;
    for (int i = 0; i < 160; i++) begin
      cyc(0, 0, 1, 9'(i), 0);
      nw += s_we;
      chk("lit_oaddr", s_oaddr, i);
    end
    cyc(0, 0, 0, 9'd0, 1);
    idle(1);
    chk("writes_160", nw, 160);
    chk("full_cnt", s_cnt, 160); chk("full_done", s_done, 1); chk("full_err", s_err, 0);

    // Overflow: 161 strobes, restart straight from DONE.
    cyc(1, 0, 0, 9'd0, 0);
    idle(256);
    nw = 0;
    for (int i = 0; i < 161; i++) begin
      cyc(0, 0, 1, 9'($urandom), 0);
      nw += s_we;
    end
    cyc(0, 0, 0, 9'd0, 1);
    idle(1);
    chk("ovf_writes", nw, 160); chk("ovf_err", s_err, 1); chk("ovf_cnt", s_cnt, 160);

    // Clear to IDLE, count holds; then read_ram and finish together after 3 results.
    cyc(0, 1, 0, 9'd0, 0);
    idle(1);
    chk("clr_done", s_done, 0); chk("clr_err", s_err, 0); chk("clr_cnt_hold", s_cnt, 160);
    cyc(1, 0, 0, 9'd0, 0);
    idle(256);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 9'($urandom), 0);
    cyc(0, 0, 1, 9'h1FF, 1);
    chk("same_we", s_we, 1); chk("same_addr", s_oaddr, 3); chk("same_data", s_wdata, 9'h1FF);
    idle(1);
    chk("same_done", s_done, 1); chk("same_cnt", s_cnt, 4);

    // Reset mid-load, then restart from byte 0.
    cyc(1, 0, 0, 9'd0, 0);
    idle(48);
    do_reset();
    cyc(1, 0, 0, 9'd0, 0);
    idle(1);
    chk("restart_valid", s_valid, 1); chk("restart_addr", s_addr, 0); chk("restart_byte", s_data, 8'h11);
    idle(255);

    // No finish in WAIT.
`ifdef MMU_TIMEOUT_EN
    idle(TMO);
    idle(1);
    chk("tmo_done", s_done, 1); chk("tmo_err", s_err, 1);
    cyc(0, 1, 0, 9'd0, 0);
`else
    idle(1000);
    chk("no_tmo_busy", s_busy, 1);
    cyc(0, 0, 0, 9'd0, 1);
    cyc(0, 1, 0, 9'd0, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      else cyc($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
               $urandom_range(0, 2) == 0, 9'($urandom), $urandom_range(0, 149) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
